// File: rtl/video_in_pkg.sv
// Shared types and helpers for the camera-bus capture block.
package video_in_pkg;

   typedef enum logic [1:0] {
      SYNC,
      VBLANK,
      HBLANK,
      LINE
   } state_t;

   localparam int ERR_LONG  = 0;
   localparam int ERR_SHORT = 1;
   localparam int ERR_FRAME = 2;
   localparam int ERR_OVF   = 3;

   function automatic int word_width(input int pix_w, input int ppw);
      return pix_w * ppw;
   endfunction

endpackage

// File: rtl/video_in_pack.sv
// Packs P_PPW consecutive pixels into one word, first pixel in the MSBs.
module video_in_pack
   import video_in_pkg::*;
#(
   parameter int P_PIX_W = 8,
   parameter int P_PPW   = 4
) (
   input  logic                                   clk,
   input  logic                                   rst,
   input  logic                                   push,
   input  logic                                   flush,
   input  logic [P_PIX_W-1:0]                     pixel,
   output logic [word_width(P_PIX_W, P_PPW)-1:0]  word,
   output logic                                   word_done
);

   localparam int WORD_W = word_width(P_PIX_W, P_PPW);
   localparam int CNT_W  = (P_PPW > 1) ? $clog2(P_PPW) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(P_PPW - 1);

   logic [WORD_W-1:0] sh_q, sh_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;

   always_comb begin
      sh_d      = sh_q;
      cnt_d     = cnt_q;
      word_done = 1'b0;
      if (flush) begin
         cnt_d = '0;
      end else if (push) begin
         // The word is handed out combinationally on the completing push.
         sh_d = (sh_q << P_PIX_W) | WORD_W'(pixel);
         if (cnt_q == CNT_LAST) begin
            cnt_d     = '0;
            word_done = 1'b1;
         end else begin
            cnt_d = cnt_q + CNT_W'(1);
         end
      end
      word = sh_d;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         sh_q  <= '0;
         cnt_q <= '0;
      end else begin
         sh_q  <= sh_d;
         cnt_q <= cnt_d;
      end
   end

endmodule

// File: rtl/video_in_capture.sv
// Camera bus capture: frame/line FSM, geometry checks, pixel packing and a
// single-entry valid/ready output register with counted drops.
module video_in_capture
   import video_in_pkg::*;
#(
   parameter int P_WIDTH  = 640,
   parameter int P_HEIGHT = 480,
   parameter int P_PIX_W  = 8,
   parameter int P_PPW    = 4,
   parameter int P_CNT_W  = 16
) (
   input  logic                         clk,
   input  logic                         RST,
   input  logic                         pix_en,
   input  logic                         frame_valid,
   input  logic                         line_valid,
   input  logic [P_PIX_W-1:0]           pixel_in,
   input  logic                         cap_en,
   output logic [P_PIX_W*P_PPW-1:0]     out_data,
   output logic                         out_valid,
   input  logic                         out_ready,
   output logic                         out_sof,
   output logic                         out_eol,
   output logic                         frame_done,
   output logic [3:0]                   err,
   input  logic                         err_clr,
   output logic [P_CNT_W-1:0]           drop_cnt
);

   localparam int WORD_W = word_width(P_PIX_W, P_PPW);
   localparam int COL_W  = $clog2(P_WIDTH + 1);
   localparam int LINE_W = $clog2(P_HEIGHT + 2);

   localparam logic [COL_W-1:0]  COL_MAX  = COL_W'(P_WIDTH);
   localparam logic [COL_W-1:0]  COL_LAST = COL_W'(P_WIDTH - 1);
   localparam logic [COL_W-1:0]  COL_SOF  = COL_W'(P_PPW - 1);
   localparam logic [LINE_W-1:0] LINE_H   = LINE_W'(P_HEIGHT);
   localparam logic [LINE_W-1:0] LINE_SAT = LINE_W'(P_HEIGHT + 1);

   generate
      if (P_WIDTH % P_PPW != 0) begin : g_bad_geometry
         $error("video_in_capture: P_WIDTH must be a multiple of P_PPW");
      end
   endgenerate

   state_t              state_q, state_d;
   logic [COL_W-1:0]    col_q, col_d;
   logic [LINE_W-1:0]   line_q, line_d;
   logic                armed_q, armed_d;
   logic                bad_q, bad_d;
   logic [WORD_W-1:0]   data_q, data_d;
   logic                valid_q, valid_d;
   logic                sof_q, sof_d;
   logic                eol_q, eol_d;
   logic                done_q, done_d;
   logic [3:0]          err_q, err_d;
   logic [P_CNT_W-1:0]  drop_q, drop_d;

   logic                push;
   logic                flush;
   logic [COL_W-1:0]    pix_col;
   logic [3:0]          err_ev;
   logic                sof_tag;
   logic                eol_tag;
   logic [WORD_W-1:0]   word;
   logic                word_done;

   video_in_pack #(
      .P_PIX_W (P_PIX_W),
      .P_PPW   (P_PPW)
   ) u_pack (
      .clk       (clk),
      .rst       (RST),
      .push      (push),
      .flush     (flush),
      .pixel     (pixel_in),
      .word      (word),
      .word_done (word_done)
   );

   always_comb begin
      state_d = state_q;
      col_d   = col_q;
      line_d  = line_q;
      armed_d = armed_q;
      bad_d   = bad_q;
      push    = 1'b0;
      flush   = 1'b0;
      pix_col = '0;
      done_d  = 1'b0;
      err_ev  = '0;

      if (pix_en) begin
         case (state_q)
            SYNC: begin
               if (!frame_valid && !line_valid) state_d = VBLANK;
            end
            VBLANK: begin
               if (frame_valid) begin
                  armed_d = cap_en;
                  line_d  = '0;
                  bad_d   = 1'b0;
                  flush   = 1'b1;
                  state_d = HBLANK;
               end
            end
            HBLANK: begin
               if (!frame_valid) begin
                  // Overlong frames were already flagged on entering line P_HEIGHT.
                  if (line_q == LINE_H) done_d = !bad_q;
                  else if (line_q < LINE_H) err_ev[ERR_FRAME] = 1'b1;
                  state_d = VBLANK;
               end else if (line_valid) begin
                  pix_col = '0;
                  push    = armed_q && (line_q < LINE_H);
                  col_d   = COL_W'(1);
                  if (line_q == LINE_H) err_ev[ERR_FRAME] = 1'b1;
                  state_d = LINE;
               end
            end
            LINE: begin
               if (!frame_valid) begin
                  err_ev[ERR_SHORT] = 1'b1;
                  err_ev[ERR_FRAME] = 1'b1;
                  flush   = 1'b1;
                  state_d = VBLANK;
               end else if (line_valid) begin
                  if (col_q < COL_MAX) begin
                     pix_col = col_q;
                     push    = armed_q && (line_q < LINE_H);
                     col_d   = col_q + COL_W'(1);
                  end else begin
                     err_ev[ERR_LONG] = 1'b1;
                  end
               end else begin
                  if (col_q != COL_MAX) begin
                     err_ev[ERR_SHORT] = 1'b1;
                     flush = 1'b1;
                  end
                  if (line_q != LINE_SAT) line_d = line_q + LINE_W'(1);
                  state_d = HBLANK;
               end
            end
            default: state_d = SYNC;
         endcase
      end

      if (|err_ev[ERR_FRAME:ERR_LONG]) bad_d = 1'b1;

      sof_tag = (line_q == '0) && (pix_col == COL_SOF);
      eol_tag = (pix_col == COL_LAST);

      data_d  = data_q;
      valid_d = valid_q;
      sof_d   = sof_q;
      eol_d   = eol_q;
      drop_d  = drop_q;
      if (valid_q && out_ready) valid_d = 1'b0;
      if (word_done) begin
         if (!valid_q || out_ready) begin
            data_d  = word;
            valid_d = 1'b1;
            sof_d   = sof_tag;
            eol_d   = eol_tag;
         end else begin
            err_ev[ERR_OVF] = 1'b1;
            if (drop_q != '1) drop_d = drop_q + P_CNT_W'(1);
         end
      end

      // A fresh event in the clearing cycle survives the clear.
      err_d = (err_clr ? 4'b0000 : err_q) | err_ev;
   end

   always_ff @(posedge clk) begin
      if (RST) begin
         state_q <= SYNC;
         col_q   <= '0;
         line_q  <= '0;
         armed_q <= 1'b0;
         bad_q   <= 1'b0;
         data_q  <= '0;
         valid_q <= 1'b0;
         sof_q   <= 1'b0;
         eol_q   <= 1'b0;
         done_q  <= 1'b0;
         err_q   <= '0;
         drop_q  <= '0;
      end else begin
         state_q <= state_d;
         col_q   <= col_d;
         line_q  <= line_d;
         armed_q <= armed_d;
         bad_q   <= bad_d;
         data_q  <= data_d;
         valid_q <= valid_d;
         sof_q   <= sof_d;
         eol_q   <= eol_d;
         done_q  <= done_d;
         err_q   <= err_d;
         drop_q  <= drop_d;
      end
   end

   assign out_data   = data_q;
   assign out_valid  = valid_q;
   assign out_sof    = sof_q;
   assign out_eol    = eol_q;
   assign frame_done = done_q;
   assign err        = err_q;
   assign drop_cnt   = drop_q;

endmodule

// File: tb/tb_video_in_capture.sv
// Directed bench for video_in_capture on an 8x2 frame, 4 pixels per word.
module tb_video_in_capture;

   logic        clk = 1'b0;
   logic        RST = 1'b1;
   logic        pix_en = 1'b0;
   logic        frame_valid = 1'b0;
   logic        line_valid = 1'b0;
   logic [7:0]  pixel_in = 8'h00;
   logic        cap_en = 1'b1;
   logic [31:0] out_data;
   logic        out_valid;
   logic        out_ready = 1'b1;
   logic        out_sof;
   logic        out_eol;
   logic        frame_done;
   logic [3:0]  err;
   logic        err_clr = 1'b0;
   logic [15:0] drop_cnt;

   video_in_capture #(
      .P_WIDTH  (8),
      .P_HEIGHT (2),
      .P_PIX_W  (8),
      .P_PPW    (4),
      .P_CNT_W  (16)
   ) dut (
      .clk         (clk),
      .RST         (RST),
      .pix_en      (pix_en),
      .frame_valid (frame_valid),
      .line_valid  (line_valid),
      .pixel_in    (pixel_in),
      .cap_en      (cap_en),
      .out_data    (out_data),
      .out_valid   (out_valid),
      .out_ready   (out_ready),
      .out_sof     (out_sof),
      .out_eol     (out_eol),
      .frame_done  (frame_done),
      .err         (err),
      .err_clr     (err_clr),
      .drop_cnt    (drop_cnt)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   int last_cyc = 0;
   int passed = 0;
   int total = 0;
   int done_cnt = 0;
   logic [31:0] wq[$];
   logic        sq[$];
   logic        eq[$];
   int          cq[$];
   int          exp_cyc[$];

   always @(posedge clk) cyc <= cyc + 1;

   // Record every word that is transferred, sampled mid-cycle.
   always @(negedge clk) begin
      if (out_valid && out_ready) begin
         wq.push_back(out_data);
         sq.push_back(out_sof);
         eq.push_back(out_eol);
         cq.push_back(cyc);
         $display("word %08h sof=%0b eol=%0b cyc=%0d", out_data, out_sof, out_eol, cyc);
      end
      if (frame_done) done_cnt++;
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) passed++;
      else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
   endtask

   function automatic logic [31:0] wd(input int i);
      if (i < wq.size()) return wq[i];
      return 'x;
   endfunction

   function automatic logic fs(input int i);
      if (i < sq.size()) return sq[i];
      return 1'bx;
   endfunction

   function automatic logic fe(input int i);
      if (i < eq.size()) return eq[i];
      return 1'bx;
   endfunction

   task automatic chk_word(input string tag, input int i, input logic [31:0] d,
                           input logic s, input logic e);
      check({tag, "_data"}, wd(i), d);
      check({tag, "_sof"}, 32'(fs(i)), 32'(s));
      check({tag, "_eol"}, 32'(fe(i)), 32'(e));
   endtask

   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   task automatic step(input logic fv, input logic lv, input logic [7:0] px);
      tick();
      pix_en = 1'b1;
      frame_valid = fv;
      line_valid = lv;
      pixel_in = px;
      last_cyc = cyc;
      tick();
      pix_en = 1'b0;
      tick();
      tick();
   endtask

   task automatic send_line(input int n, input logic [7:0] base);
      for (int i = 0; i < n; i++) begin
         step(1'b1, 1'b1, base + 8'(i));
         if (i % 4 == 3) exp_cyc.push_back(last_cyc + 1);
      end
      step(1'b1, 1'b0, 8'h00);
   endtask

   task automatic send_frame(input int nlines, input logic [7:0] base);
      step(1'b1, 1'b0, 8'h00);
      for (int l = 0; l < nlines; l++) send_line(8, base + 8'(8 * l));
      step(1'b0, 1'b0, 8'h00);
   endtask

   task automatic clear_mon();
      wq.delete();
      sq.delete();
      eq.delete();
      cq.delete();
      exp_cyc.delete();
      done_cnt = 0;
   endtask

   task automatic pulse_clr();
      tick();
      err_clr = 1'b1;
      tick();
      err_clr = 1'b0;
      tick();
   endtask

   initial begin
      // Reset asserted while the camera is mid-line.
      step(1'b1, 1'b0, 8'h00);
      step(1'b1, 1'b1, 8'hA0);
      step(1'b1, 1'b1, 8'hA1);
      check("rst_valid", 32'(out_valid), 32'h0);
      check("rst_data", out_data, 32'h0);
      check("rst_err", 32'(err), 32'h0);
      check("rst_drop", 32'(drop_cnt), 32'h0);
      check("rst_done", 32'(frame_done), 32'h0);
      tick();
      RST = 1'b0;
      for (int i = 2; i < 8; i++) step(1'b1, 1'b1, 8'hA0 + 8'(i));
      step(1'b1, 1'b0, 8'h00);
      send_line(8, 8'hB0);
      step(1'b0, 1'b0, 8'h00);
      check("partial_words", wq.size(), 32'd0);
      check("partial_done", done_cnt, 32'd0);
      check("partial_err", 32'(err), 32'h0);

      // Nominal frame.
      clear_mon();
      send_frame(2, 8'h00);
      check("nom_count", wq.size(), 32'd4);
      chk_word("nom_w0", 0, 32'h00010203, 1'b1, 1'b0);
      chk_word("nom_w1", 1, 32'h04050607, 1'b0, 1'b1);
      chk_word("nom_w2", 2, 32'h08090A0B, 1'b0, 1'b0);
      chk_word("nom_w3", 3, 32'h0C0D0E0F, 1'b0, 1'b1);
      for (int k = 0; k < 4; k++)
         check($sformatf("nom_lat%0d", k), (k < cq.size()) ? cq[k] : -1, exp_cyc[k]);
      check("nom_done", done_cnt, 32'd1);
      check("nom_err", 32'(err), 32'h0);

      // Long line then short line.
      clear_mon();
      step(1'b1, 1'b0, 8'h00);
      send_line(9, 8'h10);
      send_line(6, 8'h20);
      step(1'b0, 1'b0, 8'h00);
      check("ls_count", wq.size(), 32'd3);
      chk_word("ls_w0", 0, 32'h10111213, 1'b1, 1'b0);
      chk_word("ls_w1", 1, 32'h14151617, 1'b0, 1'b1);
      chk_word("ls_w2", 2, 32'h20212223, 1'b0, 1'b0);
      check("ls_err", 32'(err), 32'h3);
      check("ls_done", done_cnt, 32'd0);
      pulse_clr();
      check("ls_clr", 32'(err), 32'h0);

      // Overflow with the sink stalled for a whole frame.
      clear_mon();
      out_ready = 1'b0;
      send_frame(2, 8'h30);
      check("ovf_valid", 32'(out_valid), 32'h1);
      check("ovf_data", out_data, 32'h30313233);
      check("ovf_sof", 32'(out_sof), 32'h1);
      check("ovf_drop", 32'(drop_cnt), 32'd3);
      check("ovf_err", 32'(err), 32'h8);
      check("ovf_done", done_cnt, 32'd1);
      pulse_clr();
      check("ovf_clr_err", 32'(err), 32'h0);
      check("ovf_clr_drop", 32'(drop_cnt), 32'd3);
      out_ready = 1'b1;
      tick();
      tick();
      check("ovf_drain_count", wq.size(), 32'd1);
      check("ovf_drain_data", wd(0), 32'h30313233);
      check("ovf_drain_valid", 32'(out_valid), 32'h0);

      // Capture disabled at frame start, enabled mid-frame.
      clear_mon();
      cap_en = 1'b0;
      step(1'b1, 1'b0, 8'h00);
      send_line(8, 8'h40);
      cap_en = 1'b1;
      send_line(8, 8'h48);
      step(1'b0, 1'b0, 8'h00);
      check("cap_off_words", wq.size(), 32'd0);
      clear_mon();
      send_frame(2, 8'h50);
      check("cap_on_count", wq.size(), 32'd4);
      chk_word("cap_w0", 0, 32'h50515253, 1'b1, 1'b0);
      chk_word("cap_w3", 3, 32'h5C5D5E5F, 1'b0, 1'b1);
      check("cap_done", done_cnt, 32'd1);

      // Frame with three lines, then a frame with one line.
      clear_mon();
      send_frame(3, 8'h60);
      check("tall_count", wq.size(), 32'd4);
      chk_word("tall_w3", 3, 32'h6C6D6E6F, 1'b0, 1'b1);
      check("tall_err", 32'(err), 32'h4);
      check("tall_done", done_cnt, 32'd0);
      pulse_clr();
      clear_mon();
      send_frame(1, 8'h80);
      check("short_count", wq.size(), 32'd2);
      chk_word("short_w0", 0, 32'h80818283, 1'b1, 1'b0);
      chk_word("short_w1", 1, 32'h84858687, 1'b0, 1'b1);
      check("short_err", 32'(err), 32'h4);
      check("short_done", done_cnt, 32'd0);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule

// File: doc/video_in_capture.md
Name: video_in_capture

Overview:
- Parametrised successor to the video input reader: samples the camera bus (frame_valid, line_valid, pixel), packs P_PPW pixels per word and presents words on a valid/ready stream to the input FIFO.
- Adds generic pixel width, pixels per word and frame geometry; sticky error flags instead of simulation stops; backpressure with counted drops; SOF/EOL tagging; frame-atomic enable.
- Single clock: the camera bus is already synchronised upstream and qualified by pix_en.

Parameters:
- P_WIDTH, 640, active pixels per line; P_WIDTH % P_PPW == 0 is checked at elaboration.
- P_HEIGHT, 480, active lines per frame.
- P_PIX_W, 8, bits per pixel.
- P_PPW, 4, pixels per output word; word width is P_PIX_W*P_PPW.
- P_CNT_W, 16, width of the drop counter.

Ports:
- clk  in  1  system clock (100 MHz).
- RST  in  1  synchronous reset, active-high.
- pix_en  in  1  one-cycle strobe; bus inputs are sampled only when it is 1.
- frame_valid  in  1  camera frame valid.
- line_valid  in  1  camera line valid.
- pixel_in  in  P_PIX_W  pixel data.
- cap_en  in  1  capture enable, applied at frame boundaries only.
- out_data  out  P_PIX_W*P_PPW  packed word; first pixel of the group in the MSBs.
- out_valid  out  1  word available.
- out_ready  in  1  sink accepts the word.
- out_sof  out  1  qualifies out_data: first word of a frame.
- out_eol  out  1  qualifies out_data: last word of a line.
- frame_done  out  1  one-cycle pulse on each complete, error-free frame end.
- err  out  4  sticky flags: [0] line long, [1] line short, [2] frame height wrong, [3] overflow.
- err_clr  in  1  clears err.
- drop_cnt  out  P_CNT_W  dropped words; saturating.

Behaviour:
- Reset: all outputs are 0; state SYNC; column and line counters 0; packer empty.
- Bus events are evaluated only on cycles where pix_en=1. Other cycles only progress the output handshake.
- SYNC: stay until frame_valid=0 and line_valid=0, then go to VBLANK. This discards the partial frame present at reset.
- VBLANK: on frame_valid=1, latch armed=cap_en. Go to HBLANK with line=0.
  - If line_valid=1 and frame_valid=0, ignore it.
- HBLANK, frame_valid=1 and line_valid=1: go to LINE, col=0, and capture this pixel.
- HBLANK, frame_valid=0:
  - If line==P_HEIGHT, pulse frame_done one cycle later.
  - Otherwise set err[2].
  - Go to VBLANK.
- LINE, line_valid=1 and col<P_WIDTH: capture the pixel, col++.
- LINE, line_valid=1 and col==P_WIDTH: discard the pixel and set err[0].
- LINE, line_valid=0:
  - If col!=P_WIDTH, set err[1] and discard any partial word.
  - line++ (saturates at P_HEIGHT+1).
  - Go to HBLANK.
- LINE, frame_valid=0: set err[1] and err[2], discard any partial word, go to VBLANK.
- Lines beyond P_HEIGHT:
  - Set err[2].
  - Their pixels are counted but not emitted.
  - Only one err[2] per frame: this condition, and the line!=P_HEIGHT check at frame end, set the same flag.
- Capture: a pixel is shifted into the packer only if armed=1. Mid-frame changes of cap_en have no effect.
- A word completes on the pix_en cycle of its P_PPW-th pixel.
  - The word is presented with out_valid=1 on the next cycle (latency 1).
  - out_sof=1 when the word covers line 0, col 0..P_PPW-1.
  - out_eol=1 when the last pixel of the word is col P_WIDTH-1.
- Handshake: transfer happens when out_valid and out_ready are both 1. out_data, out_sof and out_eol are held stable while out_valid=1 and out_ready=0.
- Word completes while the register is empty, or is being consumed in that same cycle: load the new word.
- Word completes while out_valid=1 and out_ready=0:
  - Drop the new word; the held word is kept.
  - Set err[3].
  - drop_cnt++, saturating at all-ones.
- Errors are sticky until err_clr. If err_clr and a new error event occur in the same cycle, the new error wins.
- Errors never stall capture. The block resynchronises at the next VBLANK.
- frame_done is suppressed if any of err[0..2] was raised during that frame.
- drop_cnt is cleared only by RST.

Decomposition:
- Package video_in_pkg:
  - state enum {SYNC, VBLANK, HBLANK, LINE};
  - error index constants ERR_LONG=0, ERR_SHORT=1, ERR_FRAME=2, ERR_OVF=3;
  - word-width function.
- Sub-module video_in_pack:
  - shift/pack of P_PPW pixels;
  - inputs: push, flush, pixel;
  - outputs: word, word_done.
- Top level holds the FSM, counters, output register and error logic.

Test Plan (P_WIDTH=8, P_HEIGHT=2, P_PPW=4, P_PIX_W=8, pix_en every 4th clk):
- Nominal frame:
  - Stimulus: frame of pixels 0x00..0x0F, out_ready=1.
  - Response: 4 words, 0x00010203 (sof=1), 0x04050607 (eol=1), 0x08090A0B, 0x0C0D0E0F (eol=1); each with out_valid one clk after its 4th pixel; one frame_done; err=0.
- Reset mid-line:
  - Stimulus: RST released during line 0.
  - Response: no words until the next frame; that frame is output exactly as in the nominal case.
- Long/short lines:
  - Stimulus: line of 9 pixels, then line of 6 pixels.
  - Response: err[0] and err[1] set; 9th pixel discarded; the partial second word is not emitted; no frame_done.
- Overflow:
  - Stimulus: out_ready=0 for a whole frame.
  - Response: first word held unchanged; 3 drops; drop_cnt=3; err[3]=1. Pulse err_clr and check err returns to 0 while drop_cnt stays 3.
- Capture enable:
  - Stimulus: cap_en=0 at frame_valid rise, raised mid-frame.
  - Response: no words for that frame; the next frame is fully captured.
- Frame height:
  - Stimulus: frame with 3 lines, then a frame with 1 line.
  - Response: err[2] set; no frame_done for either frame; no words from the 3rd line.
